// File: rtl/sin_lut_arbiter_if.sv
// Request/response bus between the breathing/PWM channels and the shared
// sine lookup arbiter. The channels drive the master side and the arbiter
// is the slave side.
interface sin_lut_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 8,
  parameter int unsigned VAL_W = 8
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*IDX_W-1:0] req_idx;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [VAL_W-1:0]       rsp_data;
  logic                   busy;

  // Requester side
  modport master (
    output req,
    output req_idx,
    input  gnt,
    input  rsp_valid,
    input  rsp_data,
    input  busy
  );

  // Arbiter side
  modport slave (
    input  req,
    input  req_idx,
    output gnt,
    output rsp_valid,
    output rsp_data,
    output busy
  );

endinterface

// File: rtl/sin_lut_arbiter.sv
// Round-robin arbiter that shares one sine lookup among N_REQ channels.
// Stage 1 grants one channel per clock and captures its phase index.
// Stage 2 registers the sine value and tags it with the winning channel.
// Build option: define SIN_ARB_FIXED_PRIO_EN for fixed priority, where
// channel 0 is highest and the rotating pointer stays at 0.
// The sine table is an 8-bit phase to 8-bit value quarter-wave table:
// value = 128 + round(127 * sin(2*pi*phase/256)).
module sin_lut_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 8,
  parameter int unsigned VAL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  sin_lut_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [VAL_W-1:0] rsp_data_q;
  logic [PTR_W-1:0] ptr;

  logic             s1_v;
  logic [IDX_W-1:0] s1_idx;
  logic [PTR_W-1:0] s1_id;

  logic [N_REQ-1:0] eligible;
  logic [IDX_W-1:0] idx_arr [N_REQ];
  logic             win_found;
  logic [PTR_W-1:0] win_id;
  logic [IDX_W-1:0] win_idx;
  int unsigned      cand;

  logic [7:0]       phase;
  logic [6:0]       quarter_k;
  logic [6:0]       quarter_v;
  logic [7:0]       sine8;
  logic [VAL_W-1:0] sin_value;

  // Quarter-wave table: round(127 * sin(k * pi / 128)) for k = 0..64
  function automatic logic [6:0] quarter_sine(input logic [6:0] k);
    logic [6:0] v;
    case (k)
      7'd0:  v = 7'd0;
      7'd1:  v = 7'd3;
      7'd2:  v = 7'd6;
      7'd3:  v = 7'd9;
      7'd4:  v = 7'd12;
      7'd5:  v = 7'd16;
      7'd6:  v = 7'd19;
      7'd7:  v = 7'd22;
      7'd8:  v = 7'd25;
      7'd9:  v = 7'd28;
      7'd10: v = 7'd31;
      7'd11: v = 7'd34;
      7'd12: v = 7'd37;
      7'd13: v = 7'd40;
      7'd14: v = 7'd43;
      7'd15: v = 7'd46;
      7'd16: v = 7'd49;
      7'd17: v = 7'd51;
      7'd18: v = 7'd54;
      7'd19: v = 7'd57;
      7'd20: v = 7'd60;
      7'd21: v = 7'd63;
      7'd22: v = 7'd65;
      7'd23: v = 7'd68;
      7'd24: v = 7'd71;
      7'd25: v = 7'd73;
      7'd26: v = 7'd76;
      7'd27: v = 7'd78;
      7'd28: v = 7'd81;
      7'd29: v = 7'd83;
      7'd30: v = 7'd85;
      7'd31: v = 7'd88;
      7'd32: v = 7'd90;
      7'd33: v = 7'd92;
      7'd34: v = 7'd94;
      7'd35: v = 7'd96;
      7'd36: v = 7'd98;
      7'd37: v = 7'd100;
      7'd38: v = 7'd102;
      7'd39: v = 7'd104;
      7'd40: v = 7'd106;
      7'd41: v = 7'd107;
      7'd42: v = 7'd109;
      7'd43: v = 7'd111;
      7'd44: v = 7'd112;
      7'd45: v = 7'd113;
      7'd46: v = 7'd115;
      7'd47: v = 7'd116;
      7'd48: v = 7'd117;
      7'd49: v = 7'd118;
      7'd50: v = 7'd120;
      7'd51: v = 7'd121;
      7'd52: v = 7'd122;
      7'd53: v = 7'd122;
      7'd54: v = 7'd123;
      7'd55: v = 7'd124;
      7'd56: v = 7'd125;
      7'd57: v = 7'd125;
      7'd58: v = 7'd126;
      7'd59: v = 7'd126;
      7'd60: v = 7'd126;
      7'd61: v = 7'd127;
      7'd62: v = 7'd127;
      7'd63: v = 7'd127;
      7'd64: v = 7'd127;
      default: v = 7'd127;
    endcase
    return v;
  endfunction

  // Split the packed index bus into one entry per channel
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign idx_arr[i] = bus.req_idx[i*IDX_W +: IDX_W];
  end

  // A channel granted this cycle sits out one slot so a held req never double-issues
  assign eligible = bus.req & ~gnt_q;

  // Scan eligible requesters starting at ptr, wrapping at N_REQ
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!win_found && eligible[PTR_W'(cand)]) begin
        win_found = 1'b1;
        win_id    = PTR_W'(cand);
      end
    end
  end

  assign win_idx = idx_arr[win_id];

  // Stage 1: grant, capture index and channel, advance the pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q  <= '0;
      s1_v   <= 1'b0;
      s1_idx <= '0;
      s1_id  <= '0;
      ptr    <= '0;
    end else begin
      s1_v <= win_found;
      if (win_found) begin
        gnt_q  <= N_REQ'(1) << win_id;
        s1_idx <= win_idx;
        s1_id  <= win_id;
`ifdef SIN_ARB_FIXED_PRIO_EN
        ptr    <= '0;
`else
        ptr    <= (win_id == PTR_W'(N_REQ - 1)) ? '0 : win_id + PTR_W'(1);
`endif
      end else begin
        gnt_q <= '0;
      end
    end
  end

  // Sine lookup: fold the phase into the first quadrant, then mirror
  always_comb begin
    phase     = 8'(s1_idx);
    quarter_k = phase[6] ? (7'd64 - 7'(phase[5:0])) : 7'(phase[5:0]);
    quarter_v = quarter_sine(quarter_k);
    sine8     = phase[7] ? (8'd128 - 8'(quarter_v)) : (8'd128 + 8'(quarter_v));
    sin_value = VAL_W'(sine8);
  end

  // Stage 2: register the value and tag it with the granted channel
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= s1_v ? (N_REQ'(1) << s1_id) : '0;
      if (s1_v) begin
        rsp_data_q <= sin_value;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = s1_v;

endmodule

// File: tb/tb_sin_lut_arbiter.sv
// Bench for sin_lut_arbiter: a directed vector table for reset, single
// request, round-robin, drop-before-grant and mid-operation reset, then a
// randomized run compared against a cycle-level model with a math sine.
module tb_sin_lut_arbiter;

  localparam int N = 4;
  localparam real PI = 3.14159265358979323846;

  logic clk;
  logic rst;

  sin_lut_arbiter_if #(.N_REQ(4), .IDX_W(8), .VAL_W(8)) bus ();

  sin_lut_arbiter #(.N_REQ(4), .IDX_W(8), .VAL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] rv;
    logic       busy;
    logic       chk;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  int tests;
  int failed;
  int cyc;

  // Reference model state
  logic [3:0] m_gnt;
  logic [3:0] m_rv;
  logic [7:0] m_rd;
  int         m_ptr;
  logic       m_pend_v;
  int         m_pend_ch;
  logic [7:0] m_pend_idx;

  function automatic logic [7:0] sin_ref(input logic [7:0] idx);
    real s;
    int  r;
    s = 127.0 * $sin(2.0 * PI * real'(idx) / 256.0);
    if (s >= 0.0) r = $rtoi(s + 0.5);
    else          r = -$rtoi(-s + 0.5);
    return 8'(128 + r);
  endfunction

  // One clock edge of the arbiter as described by its rules
  function automatic void model_step(input logic rst_v, input logic [3:0] req_v,
                                     input logic [31:0] idx_v);
    int w;
    if (!rst_v) begin
      m_gnt = '0; m_rv = '0; m_rd = '0; m_ptr = 0;
      m_pend_v = 1'b0; m_pend_ch = 0; m_pend_idx = '0;
      return;
    end
    if (m_pend_v) begin
      m_rv = 4'(1 << m_pend_ch);
      m_rd = sin_ref(m_pend_idx);
    end else begin
      m_rv = '0;
    end
    w = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (w < 0 && req_v[2'(c)] && !m_gnt[2'(c)]) w = c;
    end
    if (w >= 0) begin
      m_gnt      = 4'(1 << w);
      m_pend_v   = 1'b1;
      m_pend_ch  = w;
      m_pend_idx = idx_v[w*8 +: 8];
`ifndef SIN_ARB_FIXED_PRIO_EN
      m_ptr      = (w + 1) % N;
`endif
    end else begin
      m_gnt    = '0;
      m_pend_v = 1'b0;
    end
  endfunction

  task automatic chk_bits(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input logic [7:0] act, input logic [7:0] exp);
    int d;
    tests++;
    d = int'(act) - int'(exp);
    if ($isunknown(act) || d > 1 || d < -1) begin
      failed++;
      $display("FAIL %s cycle %0d: got %0d expected %0d (+/-1)", name, cyc, act, exp);
    end
  endtask

  // Drive inputs, step the model, let the edge happen and settle past it
  task automatic apply(input logic rst_v, input logic [3:0] req_v, input logic [31:0] idx_v);
    rst         = rst_v;
    bus.req     = req_v;
    bus.req_idx = idx_v;
    model_step(rst_v, req_v, idx_v);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic [3:0] v, input logic b, input logic c,
                              input logic [7:0] d);
    vec_t e;
    e.rst = r; e.req = q; e.gnt = g; e.rv = v; e.busy = b; e.chk = c; e.data = d;
    vecs.push_back(e);
  endfunction

  // Channel phases: ch0=0x00 (128), ch1=0x20 (218), ch2=0x40 (255), ch3=0xC0 (1)
  localparam logic [31:0] TBL_IDX = 32'hC0_40_20_00;

  logic [3:0] cur_req;
  logic [7:0] cur_idx [N];
  logic [31:0] idx_pack;
  logic        rst_r;

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    bus.req = '0;
    bus.req_idx = '0;
    tests = 0;
    failed = 0;
    cyc = 0;
    m_gnt = '0; m_rv = '0; m_rd = '0; m_ptr = 0;
    m_pend_v = 1'b0; m_pend_ch = 0; m_pend_idx = '0;

`ifndef SIN_ARB_FIXED_PRIO_EN
    // Reset held with all requesting
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 1, 8'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 1, 8'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 1, 8'd0);
    // Round-robin for 8 clocks, responses trail by one
    add(1, 4'b1111, 4'b0001, 4'b0000, 1, 0, 8'd0);
    add(1, 4'b1111, 4'b0010, 4'b0001, 1, 1, 8'd128);
    add(1, 4'b1111, 4'b0100, 4'b0010, 1, 1, 8'd218);
    add(1, 4'b1111, 4'b1000, 4'b0100, 1, 1, 8'd255);
    add(1, 4'b1111, 4'b0001, 4'b1000, 1, 1, 8'd1);
    add(1, 4'b1111, 4'b0010, 4'b0001, 1, 1, 8'd128);
    add(1, 4'b1111, 4'b0100, 4'b0010, 1, 1, 8'd218);
    add(1, 4'b1111, 4'b1000, 4'b0100, 1, 1, 8'd255);
    add(1, 4'b0000, 4'b0000, 4'b1000, 0, 1, 8'd1);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 8'd1);
    // Single held request on ch2: grant every other clock
    add(1, 4'b0100, 4'b0100, 4'b0000, 1, 1, 8'd1);
    add(1, 4'b0100, 4'b0000, 4'b0100, 0, 1, 8'd255);
    add(1, 4'b0100, 4'b0100, 4'b0000, 1, 1, 8'd255);
    add(1, 4'b0000, 4'b0000, 4'b0100, 0, 1, 8'd255);
    // Drop ch1 while ch0 is granted: ch1 is never served
    add(1, 4'b0011, 4'b0001, 4'b0000, 1, 0, 8'd0);
    add(1, 4'b0001, 4'b0000, 4'b0001, 0, 1, 8'd128);
    add(1, 4'b0001, 4'b0001, 4'b0000, 1, 0, 8'd0);
    add(1, 4'b0000, 4'b0000, 4'b0001, 0, 1, 8'd128);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 8'd0);
    // Reset while ch1 is granted: its response is discarded, ptr restarts at 0
    add(1, 4'b1111, 4'b0010, 4'b0000, 1, 0, 8'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 1, 8'd0);
    add(1, 4'b1111, 4'b0001, 4'b0000, 1, 1, 8'd0);
    add(1, 4'b0000, 4'b0000, 4'b0001, 0, 1, 8'd128);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 8'd128);
`else
    // Fixed priority: ch0 and ch3 held alternate because of the gnt mask
    add(0, 4'b1001, 4'b0000, 4'b0000, 0, 1, 8'd0);
    add(0, 4'b1001, 4'b0000, 4'b0000, 0, 1, 8'd0);
    add(1, 4'b1001, 4'b0001, 4'b0000, 1, 0, 8'd0);
    add(1, 4'b1001, 4'b1000, 4'b0001, 1, 1, 8'd128);
    add(1, 4'b1001, 4'b0001, 4'b1000, 1, 1, 8'd1);
    add(1, 4'b1001, 4'b1000, 4'b0001, 1, 1, 8'd128);
    add(1, 4'b0000, 4'b0000, 4'b1000, 0, 1, 8'd1);
`endif

    #5;
    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].req, TBL_IDX);
      chk_bits("tbl_gnt", 8'(bus.gnt), 8'(vecs[i].gnt));
      chk_bits("tbl_rsp_valid", 8'(bus.rsp_valid), 8'(vecs[i].rv));
      chk_bits("tbl_busy", 8'(bus.busy), 8'(vecs[i].busy));
      if (vecs[i].chk) chk_bits("tbl_rsp_data", bus.rsp_data, vecs[i].data);
    end

    // Randomized traffic honoring the index-stability rule
    apply(1'b0, 4'b0000, 32'h0);
    cur_req = '0;
    for (int i = 0; i < N; i++) cur_idx[i] = '0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (cur_req[i] && !m_gnt[i]) begin
          if ($urandom_range(7) == 0) cur_req[i] = 1'b0;
        end else begin
          cur_req[i] = ($urandom_range(3) != 0);
          cur_idx[i] = 8'($urandom);
        end
      end
      idx_pack = {cur_idx[3], cur_idx[2], cur_idx[1], cur_idx[0]};
      rst_r = ($urandom_range(149) != 0);
      apply(rst_r, cur_req, idx_pack);
      chk_bits("rnd_gnt", 8'(bus.gnt), 8'(m_gnt));
      chk_bits("rnd_rsp_valid", 8'(bus.rsp_valid), 8'(m_rv));
      chk_bits("rnd_busy", 8'(bus.busy), 8'(m_pend_v));
      chk_near("rnd_rsp_data", bus.rsp_data, m_rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

endmodule
